// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encoding,
// default latencies and FSM states.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_mult(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
// Non-arithmetic ops and divide-by-zero return the current HI/LO unchanged.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_p_next,
  output logic [31:0] lo_p_next
);

  md_op_t      op_e;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign op_e      = md_op_t'(op);
  assign is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);

  // Extending to 64 bits lets one unsigned multiplier serve both signednesses.
  assign a_ext = {{32{is_signed & rs_val[31]}}, rs_val};
  assign b_ext = {{32{is_signed & rt_val[31]}}, rt_val};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_neg = is_signed & rs_val[31];
  assign b_neg = is_signed & rt_val[31];
  assign a_mag = a_neg ? (32'd0 - rs_val) : rs_val;
  assign b_mag = b_neg ? (32'd0 - rt_val) : rt_val;
  assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    hi_p_next = hi;
    lo_p_next = lo;
    if (is_mult(op_e)) begin
      hi_p_next = prod[63:32];
      lo_p_next = prod[31:0];
    end else if (is_div(op_e) && (rt_val != 32'd0)) begin
      hi_p_next = rem;
      lo_p_next = quot;
    end
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer beside the E stage: owns HI/LO, models the
// multi-cycle busy window and requests stalls for HI/LO-dependent D-stage ops.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYC,
  parameter int DIV_CYCLES  = MD_DIV_CYC,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_p_reg, hi_p_next;
  logic [31:0]      lo_p_reg, lo_p_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  md_op_t           op_e;

  assign op_e = md_op_t'(op);

  md_arith u_arith (
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi        (hi_reg),
    .lo        (lo_reg),
    .hi_p_next (arith_hi),
    .lo_p_next (arith_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
      hi_p_reg  <= '0;
      lo_p_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_p_reg  <= hi_p_next;
      lo_p_reg  <= lo_p_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_p_next  = hi_p_reg;
    lo_p_next  = lo_p_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      MD_IDLE: begin
        if (start) begin
          if (is_mult(op_e) || is_div(op_e)) begin
            hi_p_next  = arith_hi;
            lo_p_next  = arith_lo;
            cnt_next   = is_mult(op_e) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state_next = MD_BUSY;
          end else if (op_e == MD_MTHI) begin
            hi_next = rs_val;
          end else if (op_e == MD_MTLO) begin
            lo_next = rs_val;
          end
        end
      end
      MD_BUSY: begin
        // New starts are ignored here; the stall keeps them out of E anyway.
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          hi_next    = hi_p_reg;
          lo_next    = lo_p_reg;
          state_next = MD_IDLE;
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  assign busy     = (state_reg == MD_BUSY);
  assign stall_md = md_use_d & (busy | start);
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus random traffic,
// compared every cycle against a behavioural HI/LO model.
module tb_md_sched;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  int          m_left;

  md_sched #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Architectural result of a mult/div op from the instruction definitions.
  function automatic void ref_md(input int o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] h, input logic [31:0] l,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = h;
    rl = l;
    case (o)
      0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      1: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      2: if (b != 0) begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      3: if (b != 0) begin rl = a / b; rh = a % b; end
      default: ;
    endcase
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_ph; m_lo = m_pl; end
    end else if (start) begin
      case (int'(op))
        0, 1: begin ref_md(int'(op), rs_val, rt_val, m_hi, m_lo, m_ph, m_pl); m_left = N_MULT; end
        2, 3: begin ref_md(int'(op), rs_val, rt_val, m_hi, m_lo, m_ph, m_pl); m_left = N_DIV; end
        4: m_hi = rs_val;
        5: m_lo = rs_val;
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("stall_md", {31'd0, stall_md}, {31'd0, md_use_d & ((m_left > 0) | start)});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  // Drive one cycle: inputs applied after an edge, checked at the falling edge.
  task automatic step(input logic s, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic u);
    start = s; op = o; rs_val = a; rt_val = b; md_use_d = u;
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic u);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, u);
  endtask

  task automatic expect_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    $display("txn %s: hi=0x%08h lo=0x%08h", name, hi, lo);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic release_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 0; op = 0; rs_val = 0; rt_val = 0; md_use_d = 0;
    m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_left = 0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    release_reset();

    // MULT -2 * 3
    step(1, 3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult_busy_c1", {31'd0, busy}, 32'd1);
    idle(N_MULT, 0);
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // DIVU 100 / 7 and DIV -7 / 2
    step(1, 3'd3, 32'd100, 32'd7, 0);
    idle(N_DIV, 0);
    expect_hl("divu", 32'd2, 32'd14);
    step(1, 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    idle(N_DIV, 0);
    expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // signed overflow divide
    step(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(N_DIV, 0);
    expect_hl("div_ovf", 32'd0, 32'h8000_0000);

    // MTHI/MTLO preload then divide by zero holds HI/LO
    step(1, 3'd4, 32'h11, 32'd0, 0);
    step(1, 3'd5, 32'h22, 32'd0, 0);
    expect_hl("mthlo", 32'h11, 32'h22);
    step(1, 3'd2, 32'd55, 32'd0, 0);
    idle(N_DIV, 0);
    expect_hl("div0", 32'h11, 32'h22);

    // stall window around a MULT with a dependent op in D
    start = 1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd4; md_use_d = 1;
    #1 chk("stall_start", {31'd0, stall_md}, 32'd1);
    step(1, 3'd0, 32'd3, 32'd4, 1);
    idle(N_MULT, 1);
    chk("stall_after", {31'd0, stall_md}, 32'd0);
    expect_hl("mult_stall", 32'd0, 32'd12);
    step(1, 3'd0, 32'd5, 32'd6, 0);
    idle(N_MULT, 0);
    chk("nostall", {31'd0, stall_md}, 32'd0);

    // starts while BUSY are ignored
    step(1, 3'd1, 32'd9, 32'd9, 0);
    step(1, 3'd4, 32'hDEAD, 32'd0, 0);
    step(1, 3'd6, 32'hBEEF, 32'd1, 0);
    step(1, 3'd2, 32'd1, 32'd1, 0);
    idle(N_MULT - 3, 0);
    expect_hl("busy_ign", 32'd0, 32'd81);
    step(1, 3'd6, 32'hBEEF, 32'd1, 0);
    chk("rsvd_idle", {31'd0, busy}, 32'd0);

    // async reset in busy cycle 3 of a DIV
    step(1, 3'd2, 32'd1000, 32'd3, 0);
    idle(2, 0);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_left = 0;
    start = 0;
    release_reset();
    step(1, 3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    idle(N_MULT, 0);
    expect_hl("multu", 32'd1, 32'hFFFF_FFFE);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_val(), rand_val(),
           1'($urandom_range(0, 1)));
      if (i % 20 == 0)
        $display("txn rand %0d: busy=%0d hi=0x%08h lo=0x%08h", i, busy, hi, lo);
    end
    idle(N_DIV + 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequences the multiply/divide resource beside the E stage of the 5-stage MIPS pipeline, and owns the architectural HI/LO registers.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per issue from E.
- Models a multi-cycle busy window and commits results to HI/LO at completion.
- Raises a stall request to the hazard unit when an HI/LO-dependent instruction sits in D while the unit is busy or starting.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..2^CNT_W-1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..2^CNT_W-1)
CNT_W, 4, width of busy down-counter

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage instruction is a md op this cycle (op valid)
op  input  3  md_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5 (6,7 reserved)
rs_val  input  32  forwarded rs operand from E stage
rt_val  input  32  forwarded rt operand from E stage
md_use_d  input  1  D-stage instr is MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU
busy  output  1  unit computing; HI/LO not yet valid
stall_md  output  1  stall request to hazard unit (ORed into Stall)
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, hi=0, lo=0, pending regs=0, busy=0. Takes effect immediately mid-operation; any in-flight result is discarded.
- States: IDLE, BUSY. busy = (state==BUSY).
- IDLE, start=1, op in MULT..DIVU:
  - At the edge, compute the result from rs_val/rt_val into hi_p/lo_p.
  - Load cnt = MULT_CYCLES (mult) or DIV_CYCLES (div); go to BUSY.
- BUSY, each edge:
  - cnt = cnt-1.
  - When cnt==1 at the edge: hi<=hi_p, lo<=lo_p, go to IDLE.
  - busy is therefore high for exactly N cycles after the start edge. The new HI/LO are visible in the first cycle with busy=0.
- IDLE, start=1, op=MTHI: hi<=rs_val at that edge, lo unchanged, no busy. MTLO likewise writes lo.
- start=1 while BUSY: ignored, no state change. The hazard unit guarantees this cannot occur via stall_md.
- Reserved op with start=1: ignored.
- stall_md = md_use_d & (busy | start), combinational.
  - Stall covers start-cycle collisions, so a back-to-back mult, mult in D/E is held.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo} = product.
  - MULTU: the same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV or DIVU): hi_p/lo_p are loaded with the current hi/lo, so HI/LO are unchanged after completion. The unit still goes busy for DIV_CYCLES.
- hi/lo outputs are direct register outputs; no forwarding of pending results.
- The counter never wraps: parameters are bounded so that N fits in CNT_W. N=1 gives a single busy cycle.

Decomposition:
- Shared package md_pkg holds:
  - md_op_t encoding (MD_MULT..MD_MTLO)
  - default latency constants MD_MULT_CYC=5, MD_DIV_CYC=10
  - state enum (MD_IDLE, MD_BUSY)
- Sub-module md_arith (combinational): op, rs_val, rt_val, hi, lo -> hi_p_next, lo_p_next. It contains the signed/unsigned multiply and divide plus the divide-by-zero hold.
- md_sched keeps the FSM, counter, pending registers, HI/LO and stall logic.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 at edge 0 -> busy=1 for cycles 1..5; cycle 6: busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU rs=100, rt=7 -> busy 10 cycles, then lo=14, hi=2. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (no busy, visible next cycle); then DIV by 0 -> busy 10 cycles, hi=0x11, lo=0x22.
- MULT started with md_use_d=1 -> stall_md=1 in the start cycle and all 5 busy cycles, 0 after. With md_use_d=0 throughout -> stall_md stays 0.
- Assert reset=0 asynchronously at busy cycle 3 of a DIV -> busy, hi, lo go to 0 immediately without a clock edge. Release reset, issue MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- start with MTHI, and with reserved op 6, while BUSY -> ignored; hi unchanged after completion except for the committed mult/div result.
